// File: rtl/cordic_log_pkg.sv
// Shared types and constants for the hyperbolic-CORDIC logarithm input stage.
//  - err_t      : per-operand classification carried with each FIFO entry
//  - FP_*       : IEEE-754 single-precision field geometry
//  - entry_t    : layout of one FIFO entry at the default widths
//                 (DATA_W=32, TAG_W=4); the stage declares the same field
//                 order with its own parameter widths.
package cordic_log_pkg;

  localparam int FP_EXP_W     = 8;
  localparam int FP_MAN_W     = 23;
  localparam int FP_BIAS      = 127;
  localparam int EXP_OUT_W    = 9;
  localparam int LZ_W         = 5;
  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_TAG_W  = 4;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ZERO    = 2'd1,
    ERR_NEG     = 2'd2,
    ERR_INF_NAN = 2'd3
  } err_t;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] x;
    logic [ENTRY_DATA_W-1:0] y;
    logic [EXP_OUT_W-1:0]    exp;
    err_t                    err;
    logic [ENTRY_TAG_W-1:0]  tag;
  } entry_t;

endpackage

// File: rtl/cordic_lzc23.sv
// Combinational 23-bit leading-zero counter used to normalise subnormal
// mantissas. Only instantiated when DENORM_EN is defined.
//  i_f  : 23-bit mantissa field
//  o_lz : number of leading zeros (23 when i_f is all zero)
module cordic_lzc23
  import cordic_log_pkg::*;
(
  input  logic [FP_MAN_W-1:0] i_f,
  output logic [LZ_W-1:0]     o_lz
);

  // Later (higher) bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    o_lz = LZ_W'(FP_MAN_W);
    for (int i = 0; i < FP_MAN_W; i++) begin
      if (i_f[i]) begin
        o_lz = LZ_W'(FP_MAN_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cordic_log_input_stage.sv
// Front end of the hyperbolic-CORDIC logarithm datapath.
// Classifies IEEE-754 single operands, forms CORDIC seeds x = M+1, y = M-1
// and the unbiased exponent, and buffers results in a DEPTH-entry FIFO.
// Optional feature macro: DENORM_EN (normalise positive subnormals; when
// undefined every e==0 operand flushes to ZERO and no LZC is built).
// Ports:
//  clk, reset_n          clock, async active-low reset
//  in_valid/in_ready     operand handshake; in_fp operand, in_tag sideband
//  out_valid/out_ready   FIFO head handshake
//  out_x/out_y/out_exp   seeds and exponent of the head entry
//  out_err/out_tag       classification and tag of the head entry
//  count                 FIFO occupancy
module cordic_log_input_stage
  import cordic_log_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 25,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
)
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_fp,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_x,
  output logic [DATA_W-1:0]        out_y,
  output logic [EXP_OUT_W-1:0]     out_exp,
  output logic [1:0]               out_err,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]    x;
    logic [DATA_W-1:0]    y;
    logic [EXP_OUT_W-1:0] exp;
    err_t                 err;
    logic [TAG_W-1:0]     tag;
  } fifo_entry_t;

  logic                w_s;
  logic [FP_EXP_W-1:0] w_e;
  logic [FP_MAN_W-1:0] w_f;

  assign w_s = in_fp[31];
  assign w_e = in_fp[30:23];
  assign w_f = in_fp[22:0];

`ifdef DENORM_EN
  logic [LZ_W-1:0]      w_lz;
  logic [FP_MAN_W-1:0]  w_f_norm;
  logic [EXP_OUT_W-1:0] w_exp_sub;

  cordic_lzc23 u_lzc (
    .i_f  (w_f),
    .o_lz (w_lz)
  );

  // Shift out the leading one as well, leaving the implicit-one fraction.
  assign w_f_norm  = FP_MAN_W'(w_f << (w_lz + LZ_W'(1)));
  assign w_exp_sub = EXP_OUT_W'(-FP_BIAS) - EXP_OUT_W'(w_lz);
`endif

  fifo_entry_t          w_ent;
  logic                 w_ok;
  logic [FP_MAN_W-1:0]  w_man;
  logic [EXP_OUT_W-1:0] w_exp;

  always_comb begin
    w_ent     = '0;
    w_ent.tag = in_tag;
    w_ent.err = ERR_OK;
    w_ok      = 1'b0;
    w_man     = w_f;
    w_exp     = {1'b0, w_e} - EXP_OUT_W'(FP_BIAS);

    if (w_e == '1) begin
      w_ent.err = ERR_INF_NAN;
    end else if (w_e == '0) begin
`ifdef DENORM_EN
      if (w_f == '0) begin
        w_ent.err = ERR_ZERO;
      end else if (w_s) begin
        w_ent.err = ERR_NEG;
      end else begin
        w_ok  = 1'b1;
        w_man = w_f_norm;
        w_exp = w_exp_sub;
      end
`else
      w_ent.err = ERR_ZERO;
`endif
    end else if (w_s) begin
      w_ent.err = ERR_NEG;
    end else begin
      w_ok = 1'b1;
    end

    if (w_ok) begin
      w_ent.y   = DATA_W'(w_man) << (FRAC_W - FP_MAN_W);
      w_ent.x   = w_ent.y | (DATA_W'(2) << FRAC_W);
      w_ent.exp = w_exp;
    end
  end

  // Pointers carry one extra bit so full and empty differ at equal indices.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  fifo_entry_t  r_mem [DEPTH];
  logic [AW:0]  w_count;
  logic         w_push;
  logic         w_pop;
  fifo_entry_t  w_head;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign count     = w_count;
  assign in_ready  = (w_count != (AW+1)'(DEPTH));
  assign out_valid = (w_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_ent;
  end

  always_comb begin
    w_head = '0;
    if (out_valid) w_head = r_mem[r_rd_ptr[AW-1:0]];
  end

  assign out_x   = w_head.x;
  assign out_y   = w_head.y;
  assign out_exp = w_head.exp;
  assign out_err = w_head.err;
  assign out_tag = w_head.tag;

endmodule

// File: tb/tb_cordic_log_input_stage.sv
module tb_cordic_log_input_stage;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 25;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [8:0]  exp;
    logic [1:0]  err;
    logic [3:0]  tag;
  } ent_t;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_fp;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;
  logic [8:0]        out_exp;
  logic [1:0]        out_err;
  logic [TAG_W-1:0]  out_tag;
  logic [2:0]        count;

  int checks;
  int failures;
  ent_t q[$];

  cordic_log_input_stage #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_exp(out_exp), .out_err(out_err),
    .out_tag(out_tag), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value semantics of the operand, not the RTL structure.
  function automatic ent_t model(input logic [31:0] fp, input logic [3:0] tag);
    ent_t r;
    int   e, lz, ex;
    logic [22:0] f;
    logic s;
    bit ok;
    r = '0;
    r.tag = tag;
    s = fp[31];
    e = int'(fp[30:23]);
    f = fp[22:0];
    ok = 0;
    ex = e - 127;
    if (e == 255) r.err = 2'd3;
    else if (e == 0) begin
`ifdef DENORM_EN
      if (f == 0) r.err = 2'd1;
      else if (s) r.err = 2'd2;
      else begin
        lz = 0;
        while (f[22-lz] == 1'b0) lz++;
        f = (f << (lz + 1)) & 23'h7FFFFF;
        ex = -127 - lz;
        ok = 1;
      end
`else
      r.err = 2'd1;
`endif
    end else if (s) r.err = 2'd2;
    else ok = 1;
    if (ok) begin
      r.err = 2'd0;
      r.y   = 32'(f) * (32'd1 << (FRAC_W - 23));
      r.x   = r.y + (32'd2 << FRAC_W);
      r.exp = 9'(ex);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: v[30:23] = 8'd0;
      2: v[30:0]  = 31'd0;
      3: v[30:23] = 8'hFF;
      4: begin v[31] = 1'b0; if (v[30:23] == 8'hFF || v[30:23] == 8'h00) v[30:23] = 8'h80; end
      default: begin v[31] = 1'b0; v[22:0] = 23'd0; if (v[30:23] == 8'h00) v[30:23] = 8'h7F; end
    endcase
    return v;
  endfunction

  // Advance one clock edge and update the reference queue accordingly.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    push = in_valid && (q.size() != DEPTH);
    pop  = (q.size() != 0) && out_ready;
    e    = model(in_fp, in_tag);
    @(posedge clk); #1;
    if (pop)  q.delete(0);
    if (push) q.push_back(e);
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; in_fp = '0; in_tag = '0;
    reset_n = 0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({out_x, out_y, out_exp, out_err, out_tag} !== '0)
      begin failures++; $display("FAIL reset_outputs got x=%h y=%h exp=%h err=%0d tag=%0d exp=all0", out_x, out_y, out_exp, out_err, out_tag); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    q.delete();
  endtask

  task automatic test_vectors();
    logic [31:0] fps [7];
    logic [31:0] xs  [7];
    logic [31:0] ys  [7];
    logic [8:0]  es  [7];
    logic [1:0]  rs  [7];
    fps[0] = 32'h3F800000; xs[0] = 32'h04000000; ys[0] = 32'h0;        es[0] = 9'd0; rs[0] = 2'd0;
    fps[1] = 32'h3FC00000; xs[1] = 32'h05000000; ys[1] = 32'h01000000; es[1] = 9'd0; rs[1] = 2'd0;
    fps[2] = 32'h41000000; xs[2] = 32'h04000000; ys[2] = 32'h0;        es[2] = 9'd3; rs[2] = 2'd0;
    fps[3] = 32'hC0000000; xs[3] = 32'h0;        ys[3] = 32'h0;        es[3] = 9'd0; rs[3] = 2'd2;
    fps[4] = 32'h7F800000; xs[4] = 32'h0;        ys[4] = 32'h0;        es[4] = 9'd0; rs[4] = 2'd3;
    fps[5] = 32'h80000000; xs[5] = 32'h0;        ys[5] = 32'h0;        es[5] = 9'd0; rs[5] = 2'd1;
`ifdef DENORM_EN
    fps[6] = 32'h00400000; xs[6] = 32'h04000000; ys[6] = 32'h0;        es[6] = 9'h181; rs[6] = 2'd0;
`else
    fps[6] = 32'h00400000; xs[6] = 32'h0;        ys[6] = 32'h0;        es[6] = 9'd0;   rs[6] = 2'd1;
`endif
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_fp = fps[i]; in_tag = 4'(i + 6); out_ready = 0;
      tick();
      in_valid = 0;
      checks++; if (out_valid !== 1'b1 || count !== 3'd1)
        begin failures++; $display("FAIL vec%0d_latency got valid=%b count=%0d exp valid=1 count=1", i, out_valid, count); end
      checks++; if (out_x !== xs[i] || out_y !== ys[i])
        begin failures++; $display("FAIL vec%0d_xy got x=%h y=%h exp x=%h y=%h", i, out_x, out_y, xs[i], ys[i]); end
      checks++; if (out_exp !== es[i] || out_err !== rs[i] || out_tag !== 4'(i + 6))
        begin failures++; $display("FAIL vec%0d_exp_err got exp=%h err=%0d tag=%0d exp exp=%h err=%0d tag=%0d", i, out_exp, out_err, out_tag, es[i], rs[i], i + 6); end
      out_ready = 1;
      tick();
      out_ready = 0;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0)
        begin failures++; $display("FAIL vec%0d_pop got count=%0d valid=%b exp 0 0", i, count, out_valid); end
    end
  endtask

  task automatic test_fill();
    out_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_fp = rand_fp(); in_tag = 4'(i);
      tick();
    end
    in_fp = rand_fp(); in_tag = 4'd5;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0)
      begin failures++; $display("FAIL fill_full got count=%0d ready=%b exp 4 0", count, in_ready); end
    checks++; if (out_tag !== 4'd1)
      begin failures++; $display("FAIL fill_head got tag=%0d exp 1", out_tag); end
    // Full with a pop in the same cycle: no pass-through push.
    out_ready = 1;
    tick();
    checks++; if (count !== 3'd3 || in_ready !== 1'b1 || out_tag !== 4'd2)
      begin failures++; $display("FAIL full_pop got count=%0d ready=%b tag=%0d exp 3 1 2", count, in_ready, out_tag); end
    tick();
    in_valid = 0;
    checks++; if (count !== 3'd3 || out_tag !== 4'd3)
      begin failures++; $display("FAIL push_pop got count=%0d tag=%0d exp 3 3", count, out_tag); end
    for (int t = 3; t <= 5; t++) begin
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'(t) || {out_x, out_y, out_exp, out_err} !== {q[0].x, q[0].y, q[0].exp, q[0].err})
        begin failures++; $display("FAIL drain_order got tag=%0d x=%h err=%0d exp tag=%0d x=%h err=%0d", out_tag, out_x, out_err, t, q[0].x, q[0].err); end
      tick();
    end
    out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL drain_empty got count=%0d valid=%b exp 0 0", count, out_valid); end
  endtask

  task automatic test_random();
    ent_t eh;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      in_fp     = rand_fp();
      in_tag    = 4'($urandom);
      eh = (q.size() != 0) ? q[0] : '0;
      checks++;
      if (count !== 3'(q.size()) || in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0)
          || out_x !== eh.x || out_y !== eh.y || out_exp !== eh.exp || out_err !== eh.err || out_tag !== eh.tag) begin
        failures++;
        $display("FAIL random_c%0d got cnt=%0d rdy=%b vld=%b x=%h y=%h exp=%h err=%0d tag=%0d exp cnt=%0d x=%h y=%h exp=%h err=%0d tag=%0d",
                 c, count, in_ready, out_valid, out_x, out_y, out_exp, out_err, out_tag,
                 q.size(), eh.x, eh.y, eh.exp, eh.err, eh.tag);
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 8; c++) tick();
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    ent_t e;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_fp = 32'h3FC00000; in_tag = 4'(9 + i);
      tick();
    end
    in_valid = 0;
    checks++; if (count !== 3'd3)
      begin failures++; $display("FAIL premid_count got=%0d exp 3", count); end
    #2 reset_n = 0;
    #1;
    q.delete();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL async_reset got valid=%b count=%0d ready=%b exp 0 0 1", out_valid, count, in_ready); end
    #2 reset_n = 1;
    in_valid = 1; in_fp = 32'h41000000; in_tag = 4'd7;
    e = model(in_fp, in_tag);
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || count !== 3'd1 || out_tag !== 4'd7 || out_exp !== 9'd3 || out_x !== e.x)
      begin failures++; $display("FAIL post_reset_push got valid=%b count=%0d tag=%0d exp=%h x=%h exp 1 1 7 003 %h", out_valid, count, out_tag, out_exp, out_x, e.x); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_vectors();
    test_fill();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
